prv_trap_ctrl: RTL

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

---
 rtl/prv_trap_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl: machine-mode trap/return sequencer that latches trap CSRs and redirects the PC
// Ports:
//   CLK, nRST                   clock (rising edge), synchronous active-low reset
//   exc_req[8:0]                {fault_s, fault_l, mal_s, mal_l, env, breakpoint, illegal_insn, mal_insn, fault_insn}
//   ret                         MRET retiring
//   epc, badaddr                faulting/interrupted PC and faulting address
//   pipe_clear                  pipeline drained, safe to redirect
//   irq_pend, irq_en            {ext, soft, timer} pending and per-source enable
//   mstatus_mie                 global interrupt enable
//   mtvec                       [31:2] base, [1:0] mode
//   priv_pc, insert_pc          redirect target and one-cycle redirect strobe
//   intr                        trap pending, flush request to the hazard unit
//   mepc, mcause, mtval         trap CSR registers
//   mie_clr, mie_restore        one-cycle pulses to the mstatus logic
// Build option: define VECTORED_INT_EN to enable vectored interrupt targets when mtvec[1:0] == 2'b01.
module prv_trap_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [8:0]  exc_req,
  input  logic        ret,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        pipe_clear,
  input  logic [2:0]  irq_pend,
  input  logic [2:0]  irq_en,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  output logic [31:0] priv_pc,
  output logic        insert_pc,
  output logic        intr,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        mie_clr,
  output logic        mie_restore
);
  typedef enum logic [1:0] {IDLE, TRAP_WAIT, RET_WAIT, INSERT} state_t;
  state_t state, state_nxt;
  logic [2:0] irq_act;
  logic exc, irq_take, trap_take, tval_sel, ret_insert;
  logic [31:0] cause_nxt, base, trap_pc;
  logic unused_epc;
  assign irq_act = irq_pend & irq_en;
  assign exc = |exc_req;
  assign irq_take = mstatus_mie && |irq_act;
  assign trap_take = exc || irq_take;
  assign base = {mtvec[31:2], 2'b00};
  assign unused_epc = ^epc[1:0];
  // exc_req bit order already matches exception priority, so the lowest set bit wins
  always_comb begin
    cause_nxt = exc_req[0] ? 32'd1 :
                exc_req[1] ? 32'd0 :
                exc_req[2] ? 32'd2 :
                exc_req[3] ? 32'd3 :
                exc_req[4] ? 32'd11 :
                exc_req[5] ? 32'd4 :
                exc_req[6] ? 32'd6 :
                exc_req[7] ? 32'd5 :
                exc_req[8] ? 32'd7 :
                irq_act[2] ? 32'h8000_000B :
                irq_act[1] ? 32'h8000_0003 : 32'h8000_0007;
    tval_sel = exc && !(cause_nxt inside {32'd2, 32'd3, 32'd11});
  end
`ifdef VECTORED_INT_EN
  assign trap_pc = (mcause[31] && mtvec[1:0] == 2'b01) ? base + {25'd0, mcause[4:0], 2'b00} : base;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  assign trap_pc = base;
`endif
  always_ff @(posedge CLK)
    if (!nRST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (trap_take ? TRAP_WAIT : ret ? RET_WAIT : IDLE) :
                state == INSERT ? IDLE :
                pipe_clear ? INSERT : state;
    intr = state == TRAP_WAIT;
    insert_pc = state == INSERT;
    mie_restore = state == INSERT && ret_insert;
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      priv_pc <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      mie_clr <= 1'b0;
      ret_insert <= 1'b0;
    end else begin
      mie_clr <= state == IDLE && trap_take;
      if (state == IDLE && trap_take) begin
        mepc <= {epc[31:2], 2'b00};
        mcause <= cause_nxt;
        mtval <= tval_sel ? badaddr : 32'd0;
      end
      // target is captured on the edge into INSERT so it stays stable until the next redirect
      if ((state == TRAP_WAIT || state == RET_WAIT) && pipe_clear) begin
        priv_pc <= state == RET_WAIT ? mepc : trap_pc;
        ret_insert <= state == RET_WAIT;
      end
    end
endmodule
